// File: rtl/axis_width_adapter.sv
// axis_width_adapter: AXI-Stream width converter; pass-through, upsize or downsize in whole segments.
module axis_width_adapter #(
  parameter int S_DATA_WIDTH  = 8,
  parameter bit S_KEEP_ENABLE = (S_DATA_WIDTH > 8),
  parameter int S_KEEP_WIDTH  = (S_DATA_WIDTH + 7) / 8,
  parameter int M_DATA_WIDTH  = 8,
  parameter bit M_KEEP_ENABLE = (M_DATA_WIDTH > 8),
  parameter int M_KEEP_WIDTH  = (M_DATA_WIDTH + 7) / 8,
  parameter bit ID_ENABLE     = 0,
  parameter int ID_WIDTH      = 8,
  parameter bit DEST_ENABLE   = 0,
  parameter int DEST_WIDTH    = 8,
  parameter bit USER_ENABLE   = 1,
  parameter int USER_WIDTH    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [ID_WIDTH-1:0]     s_axis_tid,
  input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [ID_WIDTH-1:0]     m_axis_tid,
  output logic [DEST_WIDTH-1:0]   m_axis_tdest,
  output logic [USER_WIDTH-1:0]   m_axis_tuser
);
  localparam int S_KEEP_WIDTH_INT = S_KEEP_ENABLE ? S_KEEP_WIDTH : 1;
  localparam int M_KEEP_WIDTH_INT = M_KEEP_ENABLE ? M_KEEP_WIDTH : 1;
  localparam int SEG_WIDTH = S_DATA_WIDTH / S_KEEP_WIDTH_INT;
  localparam int M_SEG_WIDTH = M_DATA_WIDTH / M_KEEP_WIDTH_INT;
  localparam int SEG_COUNT = S_KEEP_WIDTH_INT > M_KEEP_WIDTH_INT ? S_KEEP_WIDTH_INT : M_KEEP_WIDTH_INT;
  localparam int MIN_KEEP = S_KEEP_WIDTH_INT < M_KEEP_WIDTH_INT ? S_KEEP_WIDTH_INT : M_KEEP_WIDTH_INT;
  localparam int EXPAND = SEG_COUNT / MIN_KEEP;
  localparam int CW = EXPAND > 1 ? $clog2(EXPAND) : 1;
  if (S_DATA_WIDTH % S_KEEP_WIDTH_INT != 0 || M_DATA_WIDTH % M_KEEP_WIDTH_INT != 0 ||
      SEG_WIDTH != M_SEG_WIDTH || SEG_COUNT % MIN_KEEP != 0) begin : g_bad_cfg
    $error("axis_width_adapter: segment sizes must match and widths must divide evenly");
  end
  logic [S_KEEP_WIDTH_INT-1:0] s_keep;
  logic [M_KEEP_WIDTH_INT-1:0] m_keep;
  logic [ID_WIDTH-1:0] m_id;
  logic [DEST_WIDTH-1:0] m_dest;
  logic [USER_WIDTH-1:0] m_user;
  assign s_keep = S_KEEP_ENABLE ? S_KEEP_WIDTH_INT'(s_axis_tkeep) : '1;
  assign m_axis_tkeep = M_KEEP_ENABLE ? M_KEEP_WIDTH'(m_keep) : '1;
  assign m_axis_tid = ID_ENABLE ? m_id : '0;
  assign m_axis_tdest = DEST_ENABLE ? m_dest : '0;
  assign m_axis_tuser = USER_ENABLE ? m_user : '0;
  if (S_KEEP_WIDTH_INT == M_KEEP_WIDTH_INT) begin : g_pass
    assign m_axis_tdata = s_axis_tdata;
    assign m_keep = s_keep;
    assign m_axis_tvalid = s_axis_tvalid;
    assign m_axis_tlast = s_axis_tlast;
    assign s_axis_tready = m_axis_tready;
    assign m_id = s_axis_tid;
    assign m_dest = s_axis_tdest;
    assign m_user = s_axis_tuser;
  end else if (M_KEEP_WIDTH_INT > S_KEEP_WIDTH_INT) begin : g_up
    logic [M_DATA_WIDTH-1:0] data_q, data_d;
    logic [M_KEEP_WIDTH_INT-1:0] keep_d;
    logic [CW-1:0] cnt;
    logic valid_q, last_q, accept;
    assign s_axis_tready = !valid_q || m_axis_tready;
    assign accept = s_axis_tvalid && s_axis_tready;
    assign m_axis_tdata = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast = last_q;
    // Slot 0 starts a fresh word, so unfilled upper slots read back as zero.
    always_comb begin
      data_d = cnt == '0 ? '0 : data_q;
      keep_d = cnt == '0 ? '0 : m_keep;
      data_d[cnt*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
      keep_d[cnt*S_KEEP_WIDTH_INT +: S_KEEP_WIDTH_INT] = s_keep;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q <= '0;
        m_keep <= '0;
        m_id <= '0;
        m_dest <= '0;
        m_user <= '0;
        cnt <= '0;
        valid_q <= 1'b0;
        last_q <= 1'b0;
      end else begin
        if (valid_q && m_axis_tready) valid_q <= 1'b0;
        if (accept) begin
          data_q <= data_d;
          m_keep <= keep_d;
          last_q <= s_axis_tlast;
          m_id <= s_axis_tid;
          m_dest <= s_axis_tdest;
          m_user <= s_axis_tuser;
          if (s_axis_tlast || cnt == CW'(EXPAND - 1)) begin
            cnt <= '0;
            valid_q <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
      end
    end
  end else begin : g_down
    logic [S_DATA_WIDTH-1:0] data_q;
    logic [S_KEEP_WIDTH_INT-1:0] keep_q;
    logic [CW-1:0] cnt, end_q, end_d, hi;
    logic valid_q, last_q, fin, accept;
    assign fin = cnt == end_q;
    assign s_axis_tready = !valid_q || (m_axis_tready && fin);
    assign accept = s_axis_tvalid && s_axis_tready;
    assign m_axis_tdata = data_q[cnt*M_DATA_WIDTH +: M_DATA_WIDTH];
    assign m_keep = keep_q[cnt*M_KEEP_WIDTH_INT +: M_KEEP_WIDTH_INT];
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast = last_q && fin;
    // A tlast word ends at its highest populated segment; an empty one still emits segment 0.
    always_comb begin
      hi = '0;
      for (int i = 0; i < EXPAND; i++) hi = |s_keep[i*M_KEEP_WIDTH_INT +: M_KEEP_WIDTH_INT] ? CW'(i) : hi;
      end_d = s_axis_tlast ? hi : CW'(EXPAND - 1);
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q <= '0;
        keep_q <= '0;
        m_id <= '0;
        m_dest <= '0;
        m_user <= '0;
        cnt <= '0;
        end_q <= '0;
        valid_q <= 1'b0;
        last_q <= 1'b0;
      end else begin
        if (valid_q && m_axis_tready) begin
          cnt <= fin ? '0 : cnt + 1'b1;
          if (fin) valid_q <= 1'b0;
        end
        if (accept) begin
          data_q <= s_axis_tdata;
          keep_q <= s_keep;
          last_q <= s_axis_tlast;
          end_q <= end_d;
          m_id <= s_axis_tid;
          m_dest <= s_axis_tdest;
          m_user <= s_axis_tuser;
          cnt <= '0;
          valid_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_axis_width_adapter.sv
// tb_axis_width_adapter: checks an 8->32 upsizer and a 32->8 downsizer against a frame-level model.
module tb_axis_width_adapter;
  typedef struct packed { logic [7:0] data; logic last; logic [3:0] id; logic user; } in_t;
  typedef struct packed { logic [31:0] data; logic [3:0] keep; logic last; logic [3:0] id; logic user; } word_t;
  typedef struct packed { logic [7:0] data; logic keep; logic last; logic [3:0] id; logic user; } seg_t;

  logic clk = 0, rst = 1, m_ready = 1;
  int total = 0, passed = 0, rdy_mode = 0;
  always #5 clk = ~clk;

  logic [7:0] up_s_tdata, up_s_tdest, up_m_tdest;
  logic up_s_tkeep, up_s_tvalid, up_s_tready, up_s_tlast, up_s_tuser;
  logic [3:0] up_s_tid, up_m_tid, up_m_tkeep;
  logic [31:0] up_m_tdata;
  logic up_m_tvalid, up_m_tlast, up_m_tuser;

  logic [31:0] dn_s_tdata;
  logic [3:0] dn_s_tkeep, dn_s_tid, dn_m_tid;
  logic [7:0] dn_s_tdest, dn_m_tdest, dn_m_tdata;
  logic dn_s_tvalid, dn_s_tready, dn_s_tlast, dn_s_tuser;
  logic dn_m_tkeep, dn_m_tvalid, dn_m_tlast, dn_m_tuser;

  axis_width_adapter #(.S_DATA_WIDTH(8), .M_DATA_WIDTH(32), .ID_ENABLE(1), .ID_WIDTH(4)) u_up (
    .clk(clk), .rst(rst),
    .s_axis_tdata(up_s_tdata), .s_axis_tkeep(up_s_tkeep), .s_axis_tvalid(up_s_tvalid),
    .s_axis_tready(up_s_tready), .s_axis_tlast(up_s_tlast), .s_axis_tid(up_s_tid),
    .s_axis_tdest(up_s_tdest), .s_axis_tuser(up_s_tuser),
    .m_axis_tdata(up_m_tdata), .m_axis_tkeep(up_m_tkeep), .m_axis_tvalid(up_m_tvalid),
    .m_axis_tready(m_ready), .m_axis_tlast(up_m_tlast), .m_axis_tid(up_m_tid),
    .m_axis_tdest(up_m_tdest), .m_axis_tuser(up_m_tuser));

  axis_width_adapter #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(8), .M_KEEP_ENABLE(1), .ID_ENABLE(1), .ID_WIDTH(4)) u_dn (
    .clk(clk), .rst(rst),
    .s_axis_tdata(dn_s_tdata), .s_axis_tkeep(dn_s_tkeep), .s_axis_tvalid(dn_s_tvalid),
    .s_axis_tready(dn_s_tready), .s_axis_tlast(dn_s_tlast), .s_axis_tid(dn_s_tid),
    .s_axis_tdest(dn_s_tdest), .s_axis_tuser(dn_s_tuser),
    .m_axis_tdata(dn_m_tdata), .m_axis_tkeep(dn_m_tkeep), .m_axis_tvalid(dn_m_tvalid),
    .m_axis_tready(m_ready), .m_axis_tlast(dn_m_tlast), .m_axis_tid(dn_m_tid),
    .m_axis_tdest(dn_m_tdest), .m_axis_tuser(dn_m_tuser));

  in_t up_in[$];
  word_t up_exp[$], up_obs[$], dn_in[$];
  seg_t dn_exp[$], dn_obs[$];

  // rdy_mode: 0 always ready, 1 random, 2 toggling, 3 never ready
  initial forever begin
    @(posedge clk);
    #1;
    m_ready = (rdy_mode == 0) || (rdy_mode == 1 && $urandom_range(0, 1) == 1) || (rdy_mode == 2 && !m_ready);
  end

  always @(negedge clk) begin
    if (!rst && up_m_tvalid && m_ready) up_obs.push_back({up_m_tdata, up_m_tkeep, up_m_tlast, up_m_tid, up_m_tuser});
    if (!rst && dn_m_tvalid && m_ready) dn_obs.push_back({dn_m_tdata, dn_m_tkeep, dn_m_tlast, dn_m_tid, dn_m_tuser});
  end

  function automatic void model_up();
    logic [31:0] d = '0;
    int n = 0;
    up_exp.delete();
    foreach (up_in[i]) begin
      d = d | (32'(up_in[i].data) << (8 * n));
      n++;
      if (n == 4 || up_in[i].last) begin
        up_exp.push_back({d, 4'((1 << n) - 1), up_in[i].last, up_in[i].id, up_in[i].user});
        d = '0;
        n = 0;
      end
    end
  endfunction

  function automatic void model_dn();
    int n;
    dn_exp.delete();
    foreach (dn_in[i]) begin
      n = 4;
      if (dn_in[i].last) begin
        n = 1;
        for (int k = 0; k < 4; k++) if (dn_in[i].keep[k]) n = k + 1;
      end
      for (int k = 0; k < n; k++)
        dn_exp.push_back({dn_in[i].data[8*k +: 8], dn_in[i].keep[k], dn_in[i].last && k == n - 1, dn_in[i].id, dn_in[i].user});
    end
  endfunction

  task automatic send_up();
    int t;
    foreach (up_in[i]) begin
      {up_s_tdata, up_s_tlast, up_s_tid, up_s_tuser} = up_in[i];
      up_s_tkeep = 1'($urandom);
      up_s_tdest = 8'($urandom);
      up_s_tvalid = 1;
      t = 0;
      do begin @(negedge clk); t++; end while (!up_s_tready && t < 200);
      if (!up_s_tready) begin total++; $display("FAIL up_send_timeout: s_axis_tready=%b required 1", up_s_tready); end
      @(posedge clk);
      #1;
    end
    up_s_tvalid = 0;
  endtask

  task automatic send_dn();
    int t;
    foreach (dn_in[i]) begin
      {dn_s_tdata, dn_s_tkeep, dn_s_tlast, dn_s_tid, dn_s_tuser} = dn_in[i];
      dn_s_tdest = 8'($urandom);
      dn_s_tvalid = 1;
      t = 0;
      do begin @(negedge clk); t++; end while (!dn_s_tready && t < 200);
      if (!dn_s_tready) begin total++; $display("FAIL dn_send_timeout: s_axis_tready=%b required 1", dn_s_tready); end
      @(posedge clk);
      #1;
    end
    dn_s_tvalid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((up_obs.size() < up_exp.size() || dn_obs.size() < dn_exp.size()) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    up_in.delete(); up_exp.delete(); up_obs.delete();
    dn_in.delete(); dn_exp.delete(); dn_obs.delete();
  endtask

  task automatic test_reset();
    logic [31:0] got[10], want[10];
    #1;
    got[0] = 32'(up_m_tvalid); got[1] = 32'(dn_m_tvalid); got[2] = 32'(up_m_tlast); got[3] = 32'(dn_m_tlast);
    got[4] = up_m_tdata; got[5] = 32'(dn_m_tdata); got[6] = 32'(up_m_tdest); got[7] = 32'(up_m_tid);
    @(negedge clk);
    rst = 0;
    rdy_mode = 3;
    @(posedge clk);
    #2;
    got[8] = 32'(up_s_tready); got[9] = 32'(dn_s_tready);
    want = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 10; i++) begin
      total++;
      if (got[i] !== want[i]) $display("FAIL reset_%0d: got %h required %h", i, got[i], want[i]);
      else passed++;
    end
    rdy_mode = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_upsize();
    logic [7:0] a[7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC};
    int len;
    clear();
    for (int i = 0; i < 7; i++) up_in.push_back({a[i], i == 3 || i == 6, 4'(i), 1'(i)});
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++) up_in.push_back({8'($urandom), j == len - 1, 4'($urandom), 1'($urandom)});
    end
    model_up();
    rdy_mode = 1;
    send_up();
    drain();
    total++;
    if (up_obs.size() < 2 || up_obs[0].data !== 32'h44332211 || up_obs[0].keep !== 4'hF || up_obs[0].last !== 1'b1)
      $display("FAIL up_four_bytes: got %h required data 44332211 keep f last 1", up_obs.size() > 0 ? up_obs[0] : '0);
    else passed++;
    total++;
    if (up_obs.size() < 2 || up_obs[1].data !== 32'h00CCBBAA || up_obs[1].keep !== 4'h7 || up_obs[1].last !== 1'b1)
      $display("FAIL up_three_bytes: got %h required data 00ccbbaa keep 7 last 1", up_obs.size() > 1 ? up_obs[1] : '0);
    else passed++;
    total++;
    if (up_obs.size() != up_exp.size()) $display("FAIL up_count: got %0d beats required %0d", up_obs.size(), up_exp.size());
    else passed++;
    foreach (up_exp[i]) begin
      total++;
      if (i >= up_obs.size() || up_obs[i] !== up_exp[i])
        $display("FAIL up_beat%0d: got %h required %h", i, i < up_obs.size() ? up_obs[i] : '0, up_exp[i]);
      else passed++;
    end
    rdy_mode = 0;
  endtask

  task automatic test_downsize();
    clear();
    dn_in.push_back({32'hDDCCBBAA, 4'hF, 1'b1, 4'h3, 1'b1});
    dn_in.push_back({32'hDDCCBBAA, 4'h3, 1'b1, 4'h5, 1'b0});
    dn_in.push_back({32'h12345678, 4'h0, 1'b1, 4'h9, 1'b1});
    for (int k = 0; k < 10; k++)
      dn_in.push_back({32'($urandom), 4'($urandom), $urandom_range(0, 2) == 0, 4'($urandom), 1'($urandom)});
    model_dn();
    rdy_mode = 1;
    send_dn();
    drain();
    total++;
    if (dn_obs.size() < 7 || dn_obs[3].data !== 8'hDD || dn_obs[3].last !== 1'b1 || dn_obs[2].last !== 1'b0 ||
        dn_obs[5].data !== 8'hBB || dn_obs[5].last !== 1'b1 || dn_obs[6].keep !== 1'b0 || dn_obs[6].last !== 1'b1)
      $display("FAIL dn_frame_ends: got %0d beats, beat3 %h beat5 %h beat6 %h required dd/last, bb/last, keep0/last",
               dn_obs.size(), dn_obs.size() > 3 ? dn_obs[3] : '0, dn_obs.size() > 5 ? dn_obs[5] : '0, dn_obs.size() > 6 ? dn_obs[6] : '0);
    else passed++;
    total++;
    if (dn_obs.size() != dn_exp.size()) $display("FAIL dn_count: got %0d beats required %0d", dn_obs.size(), dn_exp.size());
    else passed++;
    foreach (dn_exp[i]) begin
      total++;
      if (i >= dn_obs.size() || dn_obs[i] !== dn_exp[i])
        $display("FAIL dn_beat%0d: got %h required %h", i, i < dn_obs.size() ? dn_obs[i] : '0, dn_exp[i]);
      else passed++;
    end
    rdy_mode = 0;
  endtask

  task automatic test_back_to_back();
    clear();
    dn_in.push_back({32'h44332211, 4'hF, 1'b0, 4'h1, 1'b0});
    dn_in.push_back({32'h88776655, 4'hF, 1'b1, 4'h2, 1'b1});
    model_dn();
    rdy_mode = 2;
    send_dn();
    drain();
    total++;
    if (dn_obs.size() != 8) $display("FAIL b2b_count: got %0d beats required 8", dn_obs.size());
    else passed++;
    foreach (dn_exp[i]) begin
      total++;
      if (i >= dn_obs.size() || dn_obs[i] !== dn_exp[i] || dn_obs[i].data !== 8'(8'h11 * (i + 1)))
        $display("FAIL b2b_beat%0d: got %h required %h", i, i < dn_obs.size() ? dn_obs[i] : '0, dn_exp[i]);
      else passed++;
    end
    rdy_mode = 0;
  endtask

  task automatic test_reset_midframe();
    clear();
    rdy_mode = 3;
    for (int i = 0; i < 4; i++) up_in.push_back({8'(8'h50 + i), i == 3, 4'h0, 1'b0});
    send_up();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (up_m_tvalid !== 1'b1) $display("FAIL rst_pending_before: m_axis_tvalid=%b required 1", up_m_tvalid);
    else passed++;
    #2 rst = 1;
    #1;
    total++;
    if (up_m_tvalid !== 1'b0) $display("FAIL rst_pending_after: m_axis_tvalid=%b required 0", up_m_tvalid);
    else passed++;
    @(negedge clk) rst = 0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    clear();
    up_in.push_back({8'hA1, 1'b0, 4'h0, 1'b0});
    up_in.push_back({8'hA2, 1'b0, 4'h0, 1'b0});
    send_up();
    #2 rst = 1;
    #1;
    total++;
    if (up_m_tvalid !== 1'b0 || up_s_tready !== 1'b1)
      $display("FAIL rst_midframe: m_axis_tvalid=%b s_axis_tready=%b required 0 and 1", up_m_tvalid, up_s_tready);
    else passed++;
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;
    clear();
    up_in.push_back({8'h11, 1'b0, 4'h0, 1'b0});
    up_in.push_back({8'h22, 1'b0, 4'h0, 1'b0});
    up_in.push_back({8'h33, 1'b0, 4'h0, 1'b0});
    up_in.push_back({8'h44, 1'b1, 4'h6, 1'b1});
    model_up();
    send_up();
    drain();
    total++;
    if (up_obs.size() != 1 || up_obs[0] !== up_exp[0] || up_obs[0].data !== 32'h44332211)
      $display("FAIL rst_clean_frame: got %0d beats first %h required 1 beat %h", up_obs.size(),
               up_obs.size() > 0 ? up_obs[0] : '0, up_exp[0]);
    else passed++;
  endtask

  initial begin
    {up_s_tdata, up_s_tkeep, up_s_tvalid, up_s_tlast, up_s_tid, up_s_tdest, up_s_tuser} = '0;
    {dn_s_tdata, dn_s_tkeep, dn_s_tvalid, dn_s_tlast, dn_s_tid, dn_s_tdest, dn_s_tuser} = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_upsize();
    test_downsize();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
